exu_alu_core: RTL and testbench
===============================

# exu_alu_core

Registered execution core of the EXU. It consumes the operand/function triple produced by the EXU operand-select stage (`alu_a`, `alu_b`, `alu_func`) and returns `alu_result`. Simple ops complete in one cycle; multiply and divide/remainder run iteratively. Valid/ready handshakes on both sides let the control path stall on multi-cycle ops.

## Interface
- `XLEN`, default `` `ISA_WIDTH `` (32): operand and result width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: the operand triple is valid.
- `in_ready` out 1: the core can accept a triple.
- `alu_a` in XLEN: operand A.
- `alu_b` in XLEN: operand B.
- `alu_func` in `` `ALU_FUNC_WIDTH ``: function code, using the `config.v` macros.
- `out_valid` out 1: `alu_result` is valid.
- `out_ready` in 1: the consumer takes the result.
- `alu_result` out XLEN: registered result.
- `busy` out 1: high in the MUL or DIV state.

## Operation
- States: IDLE, MUL, DIV, DONE. Outputs are decoded from state:
  - `in_ready` = (state == IDLE).
  - `out_valid` = (state == DONE).
  - `busy` = (state == MUL or DIV).
- Accept: `in_valid && in_ready` at a rising edge. The inputs are captured into internal registers. Input changes after acceptance are ignored.
- Single-cycle ops, computed at the accept edge, then IDLE→DONE:
  - `` `NO_FUNC ``: 0.
  - `` `ADD_S ``: a+b, mod 2^XLEN.
  - `` `SUB_S ``: a−b, mod 2^XLEN.
  - `` `EQ ``: {0…, a==b}.
  - `` `LTS ``: signed a<b.
  - `` `LTU ``: unsigned a<b.
  - `` `AND ``, `` `OR ``, `` `XOR ``: bitwise.
  - `` `SLL ``, `` `SRL ``, `` `SRA ``: shift amount is b[4:0]; upper bits of b are ignored.
  - Unknown code: result 0, treated as `NO_FUNC`.
- `` `MUL ``: low XLEN bits of a*b.
  - Shift-add, one bit of b per cycle, XLEN iterations. IDLE→MUL→DONE.
- `` `DIV ``, `` `DIVU ``, `` `REM ``, `` `REMU ``: restoring division, one quotient bit per cycle, XLEN iterations. IDLE→DIV→DONE.
  - Signed variants divide the magnitudes.
  - Sign correction is applied on the final iteration edge. This adds no extra cycle.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Divide corner cases (RISC-V semantics), resolved at the accept edge and going straight to DONE:
  - b==0: quotient = all ones, remainder = a.
  - Signed overflow (a = 0x8000_0000, b = −1): quotient = a, remainder = 0.
- Iteration counter: width clog2(XLEN)+1, reset to 0 at accept.
  - Leaves MUL/DIV on the edge where counter == XLEN−1, then clears.
- DONE: `alu_result` holds stable until `out_valid && out_ready` at an edge, then the state returns to IDLE. `alu_result` keeps its value after leaving DONE.
- `in_valid` is ignored outside IDLE. No input is queued.

## Timing
- Reset (`rst` == 0 at an edge):
  - State goes to IDLE; counter and internal registers go to 0.
  - Outputs after reset: `alu_result` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1.
  - Reset during MUL, DIV or DONE discards the op and its result.
- Latency is measured from the accept edge E0 to the first cycle with `out_valid` = 1:
  - Single-cycle ops and divide corner cases: 1 cycle (`out_valid` is high right after E0).
  - MUL and the divide family: XLEN+1 cycles; for XLEN = 32, `out_valid` rises after edge E0+32.
- `out_ready` held high: the DONE→IDLE edge is E_d. `in_ready` is high after E_d, so the next accept is no earlier than E_d+1. Peak throughput is one single-cycle op per 2 cycles.
- `out_ready` low: DONE persists indefinitely with no change to `alu_result`.
- No combinational path from `in_valid` or `out_ready` to any output.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles, then release → `alu_result` = 0, `out_valid` = 0, `in_ready` = 1, `busy` = 0.
- ADD_S, a = 0xFFFF_FFFF, b = 2 → `out_valid` 1 cycle after accept, `alu_result` = 0x0000_0001. Then EQ, a = b = 5 → result 1.
- MUL, a = 0x0001_0003, b = 0x0000_0007 → `busy` for 32 cycles, then `alu_result` = 0x0007_0015. With `out_ready` = 0 for 5 cycles, the result is held and `in_ready` stays 0.
- DIV, a = −7, b = 2 → −3 (0xFFFF_FFFD). REM with the same operands → 0xFFFF_FFFF. Each appears 33 cycles after accept.
- DIVU with b = 0, a = 9 → 0xFFFF_FFFF after 1 cycle. REM with a = 0x8000_0000, b = −1 → 0 after 1 cycle.
- Pulse `rst` low at cycle 10 of a MUL → IDLE the next cycle, `out_valid` never asserts, and a following ADD_S 1+1 returns 2.

Source files
------------

// File: rtl/exu_alu_core_if.sv
// Operand/result handshake bundle between the EXU control path and the ALU core.
// master drives operands and consumes results; slave is the ALU core itself.
interface exu_alu_core_if #(
   parameter int XLEN = 32,
   parameter int FW   = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [FW-1:0]   alu_func;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_result;
   logic            busy;

   modport master (
      output in_valid, alu_a, alu_b, alu_func, out_ready,
      input  in_ready, out_valid, alu_result, busy
   );

   modport slave (
      input  in_valid, alu_a, alu_b, alu_func, out_ready,
      output in_ready, out_valid, alu_result, busy
   );
endinterface

// File: rtl/exu_alu_core.sv
// Registered EXU execution core: single-cycle logic/arith ops, iterative
// shift-add multiply and restoring divide/remainder behind valid/ready.
//
// state  | meaning
// IDLE   | waiting for an operand triple (in_ready high)
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DONE   | alu_result valid, held until out_ready

`ifndef EXU_ALU_CFG_DEFINED
`define EXU_ALU_CFG_DEFINED
`define ISA_WIDTH      32
`define ALU_FUNC_WIDTH 5
`define NO_FUNC 5'd0
`define ADD_S   5'd1
`define SUB_S   5'd2
`define EQ      5'd3
`define LTS     5'd4
`define LTU     5'd5
`define AND     5'd6
`define OR      5'd7
`define XOR     5'd8
`define SLL     5'd9
`define SRL     5'd10
`define SRA     5'd11
`define MUL     5'd12
`define DIV     5'd13
`define DIVU    5'd14
`define REM     5'd15
`define REMU    5'd16
`endif

module exu_alu_core #(
   parameter int XLEN = `ISA_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   exu_alu_core_if.slave  bus
);
   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_result;
   logic [XLEN-1:0] r_x, r_y, r_z;   // MUL: acc/mcand/mplier, DIV: rem/divisor/quot
   logic            r_neg_q, r_neg_r, r_is_rem;

   logic            w_accept, w_last;
   logic            w_is_mul, w_is_div, w_signed_div, w_is_rem_op;
   logic            w_div_zero, w_div_ovf, w_div_corner;
   logic [XLEN-1:0] w_a, w_b, w_abs_a, w_abs_b;
   logic [XLEN-1:0] w_simple, w_corner_res, w_mul_acc;
   logic [XLEN:0]   w_trial;
   logic            w_ge;
   logic [XLEN-1:0] w_div_rem, w_div_quot, w_div_res;

   assign w_a          = bus.alu_a;
   assign w_b          = bus.alu_b;
   assign w_accept     = bus.in_valid && (r_state == S_IDLE);
   assign w_last       = (r_cnt == CW'(XLEN - 1));
   assign w_is_mul     = (bus.alu_func == `MUL);
   assign w_signed_div = (bus.alu_func == `DIV) || (bus.alu_func == `REM);
   assign w_is_rem_op  = (bus.alu_func == `REM) || (bus.alu_func == `REMU);
   assign w_is_div     = w_signed_div || (bus.alu_func == `DIVU) || w_is_rem_op;
   assign w_div_zero   = (w_b == '0);
   assign w_div_ovf    = w_signed_div && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);
   assign w_div_corner = w_is_div && (w_div_zero || w_div_ovf);
   assign w_abs_a      = (w_signed_div && w_a[XLEN-1]) ? -w_a : w_a;
   assign w_abs_b      = (w_signed_div && w_b[XLEN-1]) ? -w_b : w_b;
   assign w_corner_res = w_div_zero ? (w_is_rem_op ? w_a : '1) : (w_is_rem_op ? '0 : w_a);

   always_comb begin
      w_simple = '0;
      case (bus.alu_func)
         `ADD_S: w_simple = w_a + w_b;
         `SUB_S: w_simple = w_a - w_b;
         `EQ:    w_simple = {{(XLEN-1){1'b0}}, w_a == w_b};
         `LTS:   w_simple = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
         `LTU:   w_simple = {{(XLEN-1){1'b0}}, w_a < w_b};
         `AND:   w_simple = w_a & w_b;
         `OR:    w_simple = w_a | w_b;
         `XOR:   w_simple = w_a ^ w_b;
         `SLL:   w_simple = w_a << w_b[4:0];
         `SRL:   w_simple = w_a >> w_b[4:0];
         `SRA:   w_simple = $unsigned($signed(w_a) >>> w_b[4:0]);
         default: w_simple = '0;
      endcase
   end

   assign w_mul_acc = r_x + (r_z[0] ? r_y : '0);

   // Partial remainder stays below the divisor, so bit XLEN of the trial is its sign.
   assign w_trial    = {r_x, r_z[XLEN-1]} - {1'b0, r_y};
   assign w_ge       = ~w_trial[XLEN];
   assign w_div_rem  = w_ge ? w_trial[XLEN-1:0] : {r_x[XLEN-2:0], r_z[XLEN-1]};
   assign w_div_quot = {r_z[XLEN-2:0], w_ge};
   assign w_div_res  = r_is_rem ? (r_neg_r ? -w_div_rem  : w_div_rem)
                                : (r_neg_q ? -w_div_quot : w_div_quot);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:
            if (w_accept) begin
               if (w_is_mul)                       w_next = S_MUL;
               else if (w_is_div && !w_div_corner) w_next = S_DIV;
               else                                w_next = S_DONE;
            end
         S_MUL:  if (w_last) w_next = S_DONE;
         S_DIV:  if (w_last) w_next = S_DONE;
         S_DONE: if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_result <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_z      <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_rem <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:
               if (w_accept) begin
                  r_cnt <= '0;
                  if (w_is_mul) begin
                     r_x <= '0;
                     r_y <= w_a;
                     r_z <= w_b;
                  end else if (w_is_div && !w_div_corner) begin
                     r_x      <= '0;
                     r_y      <= w_abs_b;
                     r_z      <= w_abs_a;
                     r_neg_q  <= w_signed_div && (w_a[XLEN-1] ^ w_b[XLEN-1]);
                     r_neg_r  <= w_signed_div && w_a[XLEN-1];
                     r_is_rem <= w_is_rem_op;
                  end else if (w_div_corner) begin
                     r_result <= w_corner_res;
                  end else begin
                     r_result <= w_simple;
                  end
               end
            S_MUL: begin
               r_x   <= w_mul_acc;
               r_y   <= r_y << 1;
               r_z   <= r_z >> 1;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result <= w_mul_acc;
                  r_cnt    <= '0;
               end
            end
            S_DIV: begin
               r_x   <= w_div_rem;
               r_z   <= w_div_quot;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result <= w_div_res;
                  r_cnt    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = (r_state == S_IDLE);
   assign bus.out_valid  = (r_state == S_DONE);
   assign bus.busy       = (r_state == S_MUL) || (r_state == S_DIV);
   assign bus.alu_result = r_result;
endmodule

// File: tb/tb_exu_alu_core.sv
// Randomized and directed bench for exu_alu_core against an arithmetic
// reference of each function code and its expected latency.

`ifndef EXU_ALU_CFG_DEFINED
`define EXU_ALU_CFG_DEFINED
`define ISA_WIDTH      32
`define ALU_FUNC_WIDTH 5
`define NO_FUNC 5'd0
`define ADD_S   5'd1
`define SUB_S   5'd2
`define EQ      5'd3
`define LTS     5'd4
`define LTU     5'd5
`define AND     5'd6
`define OR      5'd7
`define XOR     5'd8
`define SLL     5'd9
`define SRL     5'd10
`define SRA     5'd11
`define MUL     5'd12
`define DIV     5'd13
`define DIVU    5'd14
`define REM     5'd15
`define REMU    5'd16
`endif

module tb_exu_alu_core;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   exu_alu_core_if #(.XLEN(32), .FW(`ALU_FUNC_WIDTH)) bus ();
   exu_alu_core #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
      int signed sa, sb;
      logic      ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         `ADD_S: return a + b;
         `SUB_S: return a - b;
         `EQ:    return (a == b) ? 32'd1 : 32'd0;
         `LTS:   return (sa < sb) ? 32'd1 : 32'd0;
         `LTU:   return (a < b) ? 32'd1 : 32'd0;
         `AND:   return a & b;
         `OR:    return a | b;
         `XOR:   return a ^ b;
         `SLL:   return a << b[4:0];
         `SRL:   return a >> b[4:0];
         `SRA:   return $unsigned(sa >>> b[4:0]);
         `MUL:   return a * b;
         `DIV:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $unsigned(sa / sb);
         `REM:   return (b == 0) ? a : ovf ? 32'd0 : $unsigned(sa % sb);
         `DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         `REMU:  return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f == `MUL) return 33;
      if (f == `DIVU || f == `REMU) return (b == 0) ? 1 : 33;
      if (f == `DIV || f == `REM)
         return ((b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      return 1;
   endfunction

   // Called one step after a rising edge with the core idle.
   task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [31:0] exp;
      int          lat, n;
      exp = ref_alu(f, a, b);
      lat = ref_lat(f, a, b);
      bus.in_valid = 1'b1;
      bus.alu_func = f;
      bus.alu_a    = a;
      bus.alu_b    = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.alu_a    = $urandom;
      bus.alu_b    = $urandom;
      bus.alu_func = 5'($urandom);
      n = 1;
      if (lat > 1) chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      while (!bus.out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_res"}, bus.alu_result, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_res"}, bus.alu_result, exp);
         chk({tag, "_hold_inrdy"}, {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "_ret_inrdy"}, {31'd0, bus.in_ready}, 32'd1);
      chk({tag, "_ret_ovld"}, {31'd0, bus.out_valid}, 32'd0);
      chk({tag, "_ret_res"}, bus.alu_result, exp);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners [5];
      corners[0] = 32'd0;
      corners[1] = 32'd1;
      corners[2] = 32'hFFFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'h7FFF_FFFF;
      case ($urandom_range(0, 3))
         1:       return 32'($urandom_range(0, 9));
         2:       return corners[$urandom_range(0, 4)];
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic seen;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_a     = '0;
      bus.alu_b     = '0;
      bus.alu_func  = '0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      chk("rst_res",   bus.alu_result, 32'd0);
      chk("rst_ovld",  {31'd0, bus.out_valid}, 32'd0);
      chk("rst_inrdy", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_busy",  {31'd0, bus.busy}, 32'd0);

      run_op("add_wrap", `ADD_S, 32'hFFFF_FFFF, 32'd2, 0);
      run_op("eq",       `EQ,    32'd5, 32'd5, 0);
      run_op("mul",      `MUL,   32'h0001_0003, 32'h0000_0007, 5);
      run_op("div",      `DIV,   32'hFFFF_FFF9, 32'd2, 1);
      run_op("rem",      `REM,   32'hFFFF_FFF9, 32'd2, 0);
      run_op("divu_z",   `DIVU,  32'd9, 32'd0, 0);
      run_op("rem_ovf",  `REM,   32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("div_ovf",  `DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("sra",      `SRA,   32'h8000_0010, 32'hFFFF_FFE4, 0);

      // Reset pulse ten cycles into a multiply discards it.
      bus.in_valid = 1'b1;
      bus.alu_func = `MUL;
      bus.alu_a    = 32'd123;
      bus.alu_b    = 32'd456;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("mrst_inrdy", {31'd0, bus.in_ready}, 32'd1);
      chk("mrst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("mrst_res",   bus.alu_result, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("mrst_noval", {31'd0, seen}, 32'd0);
      run_op("add_after", `ADD_S, 32'd1, 32'd1, 0);

      for (int k = 0; k < 120; k++) begin
         logic [4:0] f;
         f = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 16));
         run_op($sformatf("rnd%0d_f%0d", k, f), f, pick_operand(), pick_operand(),
                $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
